// File: rtl/phy_rx_pkg.sv
// Shared constants and types for the PHY receive lane.
// The aligner and the downstream byte-to-word stage both use these.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_K285       = 8'hBC;
  localparam int         DEFAULT_BC_COUNT = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_serial_aligner.sv
// Serial comma aligner: finds byte alignment on a run of commas, then
// deserialises MSB-first bytes and marks non-comma bytes as valid payload.
module rx_serial_aligner
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA    = COMMA_K285,
  parameter int         BC_COUNT = DEFAULT_BC_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       byte_strobe,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  rx_state_e  state_q, state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       strobe_q, strobe_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic [7:0] win;
  logic       win_is_comma;
  logic       boundary;

  assign win          = {sr_q[6:0], serial_in};
  assign win_is_comma = (win == COMMA);
  assign boundary     = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    valid_d   = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        bc_cnt_d  = '0;
        if (win_is_comma) begin
          bc_cnt_d = 4'd1;
          if (BC_TARGET == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = LOCKING;
          end
        end
      end

      LOCKING: begin
        if (boundary) begin
          if (win_is_comma) begin
            // bc_cnt never passes BC_TARGET: reaching it leaves LOCKING
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_d == BC_TARGET) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            bc_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        if (boundary) begin
          data_d   = win;
          strobe_d = 1'b1;
          valid_d  = !win_is_comma;
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= win;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign byte_strobe = strobe_q;
  assign valid_out   = valid_q;
  assign active      = active_q;

endmodule

// File: tb/tb_rx_serial_aligner.sv
// Bench for rx_serial_aligner: directed scenarios plus randomized streams,
// checked every cycle against a time-indexed behavioural model.
module tb_rx_serial_aligner;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         BC    = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       byte_strobe;
  logic       valid_out;
  logic       active;

  int total = 0;
  int bad   = 0;

  // model: absolute sample time, next expected boundary time, comma count
  logic [7:0] m_hist;
  bit         m_aligned, m_locked;
  int         m_commas, m_t, m_next;
  logic [7:0] e_data;
  logic       e_strobe, e_valid;

  rx_serial_aligner #(.COMMA(COMMA), .BC_COUNT(BC)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .byte_strobe (byte_strobe),
    .valid_out   (valid_out),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic b);
    logic [7:0] w;
    if (r) begin
      m_hist = '0; m_aligned = 0; m_locked = 0; m_commas = 0;
      e_data = '0; e_strobe = 0; e_valid = 0;
      return;
    end
    w = {m_hist[6:0], b};
    m_hist = w;
    m_t++;
    e_strobe = 0;
    e_valid  = 0;
    if (m_locked) begin
      if (m_t == m_next) begin
        e_strobe = 1; e_data = w; e_valid = (w != COMMA); m_next += 8;
      end
    end else if (m_aligned) begin
      if (m_t == m_next) begin
        if (w == COMMA) begin
          m_commas++; m_next += 8;
          if (m_commas == BC) m_locked = 1;
        end else begin
          m_aligned = 0; m_commas = 0;
        end
      end
    end else if (w == COMMA) begin
      m_aligned = 1; m_commas = 1; m_next = m_t + 8;
      if (m_commas == BC) m_locked = 1;
    end
  endtask

  task automatic step(input logic r, input logic b);
    reset = r;
    serial_in = b;
    @(posedge clk_32f);
    #1;
    model(r, b);
    check("active", 32'(active), 32'(m_locked));
    check("strobe", 32'(byte_strobe), 32'(e_strobe));
    check("valid", 32'(valid_out), 32'(e_valid));
    check("data", 32'(data_out), 32'(e_data));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
  endtask

  initial begin
    m_t = 0; m_next = 0;
    model(1'b1, 1'b0);
    reset = 1'b1;
    serial_in = 1'b0;

    // 1: reset held with random serial data
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    check("rst_active", 32'(active), 32'd0);

    // 2: aligned lock then first payload byte, next strobe 8 cycles on
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    check("lock_after_4", 32'(active), 32'd1);
    send_byte(8'hCF);
    check("cf_strobe", 32'(byte_strobe), 32'd1);
    check("cf_data", 32'(data_out), 32'hCF);
    check("cf_valid", 32'(valid_out), 32'd1);
    send_byte(8'h3C);
    check("spacing8", 32'(byte_strobe), 32'd1);

    // 3: lock at a 3-bit offset
    step(1'b1, 1'b0);
    send_bits(8'b101, 3);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    send_byte(8'h5A);
    check("off3_data", 32'(data_out), 32'h5A);

    // 4: broken comma run restarts the search
    step(1'b1, 1'b0);
    send_byte(COMMA); send_byte(COMMA); send_byte(8'h00);
    check("broken_run", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    check("three_not_enough", 32'(active), 32'd0);
    send_byte(COMMA);
    check("relock", 32'(active), 32'd1);

    // 5: mid-stream comma is idle
    send_byte(COMMA);
    check("idle_data", 32'(data_out), 32'hBC);
    check("idle_valid", 32'(valid_out), 32'd0);

    // 6: reset mid-byte while active
    send_bits(8'hA5, 5);
    step(1'b1, 1'b1);
    check("rst_mid_active", 32'(active), 32'd0);
    check("rst_mid_data", 32'(data_out), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    send_byte(8'h77);
    check("needs_full_run", 32'(active), 32'd0);

    // randomized streams: junk bits, comma bursts, payload, glitches, resets
    for (int it = 0; it < 60; it++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        step(1'b1, 1'($urandom));
      end else if (sel < 3) begin
        send_bits(8'($urandom), int'($urandom_range(1, 7)));
      end else if (sel < 6) begin
        for (int k = 0; k < int'($urandom_range(1, 5)); k++) send_byte(COMMA);
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++)
          send_byte(($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
